// File: rtl/radio_bridge_pkg.sv
// Shared types and defaults for the radio bridge: mode states, gain-bus select
// and the settle-counter width.
package radio_bridge_pkg;

  localparam int DEF_DAC_WIDTH     = 16;
  localparam int DEF_ADC_WIDTH     = 14;
  localparam int DEF_RSSI_WIDTH    = 10;
  localparam int DEF_TX_GAIN_WIDTH = 6;
  localparam int DEF_RF_GAIN_WIDTH = 2;
  localparam int DEF_BB_GAIN_WIDTH = 5;
  localparam int DEF_B_WIDTH       = 7;
  localparam int DEF_TX_SETTLE     = 8;
  localparam int DEF_RX_SETTLE     = 16;
  localparam int CNT_W             = 8;

  typedef enum logic [2:0] {
    IDLE,
    TX_SETUP,
    TX_ACTIVE,
    TX_DRAIN,
    RX_SETUP,
    RX_ACTIVE
  } state_e;

  typedef enum logic [1:0] {
    GSEL_ZERO,
    GSEL_TX,
    GSEL_RX
  } gain_sel_e;

  // The counter runs from SETTLE-1 down to 0, so SETTLE cycles are spent in setup.
  function automatic logic [CNT_W-1:0] settle_load(input int unsigned settle);
    return CNT_W'(settle - 1);
  endfunction

endpackage

// File: rtl/radio_bridge_seq_if.sv
// Bundle of controller, user and radio-board signals of the radio bridge.
// "slave" is the bridge's view, "master" is the surrounding logic's view.
interface radio_bridge_seq_if
  import radio_bridge_pkg::*;
#(
  parameter int DAC_WIDTH     = DEF_DAC_WIDTH,
  parameter int ADC_WIDTH     = DEF_ADC_WIDTH,
  parameter int RSSI_WIDTH    = DEF_RSSI_WIDTH,
  parameter int TX_GAIN_WIDTH = DEF_TX_GAIN_WIDTH,
  parameter int RF_GAIN_WIDTH = DEF_RF_GAIN_WIDTH,
  parameter int BB_GAIN_WIDTH = DEF_BB_GAIN_WIDTH,
  parameter int B_WIDTH       = DEF_B_WIDTH
) ();

  logic                            controller_TxEn;
  logic                            controller_RxEn;
  logic        [TX_GAIN_WIDTH-1:0] user_Tx_gain;
  logic        [RF_GAIN_WIDTH-1:0] user_RxRF_gain;
  logic        [BB_GAIN_WIDTH-1:0] user_RxBB_gain;
  logic signed [DAC_WIDTH-1:0]     user_DAC_I;
  logic signed [DAC_WIDTH-1:0]     user_DAC_Q;
  logic signed [ADC_WIDTH-1:0]     radio_ADC_I;
  logic signed [ADC_WIDTH-1:0]     radio_ADC_Q;
  logic        [RSSI_WIDTH-1:0]    radio_RSSI_ADC_D;

  logic signed [DAC_WIDTH-1:0]     radio_DAC_I;
  logic signed [DAC_WIDTH-1:0]     radio_DAC_Q;
  logic signed [ADC_WIDTH-1:0]     user_ADC_I;
  logic signed [ADC_WIDTH-1:0]     user_ADC_Q;
  logic                            user_ADC_valid;
  logic        [RSSI_WIDTH-1:0]    user_RSSI_ADC_D;
  logic                            radio_TxEn;
  logic                            radio_RxEn;
  logic        [B_WIDTH-1:0]       radio_B;
  logic                            tx_ready;
  logic                            rx_ready;
  logic                            mode_conflict;

  modport master (
    output controller_TxEn, controller_RxEn,
    output user_Tx_gain, user_RxRF_gain, user_RxBB_gain,
    output user_DAC_I, user_DAC_Q,
    output radio_ADC_I, radio_ADC_Q, radio_RSSI_ADC_D,
    input  radio_DAC_I, radio_DAC_Q,
    input  user_ADC_I, user_ADC_Q, user_ADC_valid, user_RSSI_ADC_D,
    input  radio_TxEn, radio_RxEn, radio_B,
    input  tx_ready, rx_ready, mode_conflict
  );

  modport slave (
    input  controller_TxEn, controller_RxEn,
    input  user_Tx_gain, user_RxRF_gain, user_RxBB_gain,
    input  user_DAC_I, user_DAC_Q,
    input  radio_ADC_I, radio_ADC_Q, radio_RSSI_ADC_D,
    output radio_DAC_I, radio_DAC_Q,
    output user_ADC_I, user_ADC_Q, user_ADC_valid, user_RSSI_ADC_D,
    output radio_TxEn, radio_RxEn, radio_B,
    output tx_ready, rx_ready, mode_conflict
  );

endinterface

// File: rtl/radio_mode_fsm.sv
// Tx/Rx mode sequencer: orders enable, gain and data gating around the settle
// counters. Enables/ready are registered from the next state.
module radio_mode_fsm
  import radio_bridge_pkg::*;
#(
  parameter int TX_SETTLE = DEF_TX_SETTLE,
  parameter int RX_SETTLE = DEF_RX_SETTLE
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      tx_req,
  input  logic      rx_req,
  output logic      tx_en,
  output logic      rx_en,
  output logic      tx_ready,
  output logic      rx_ready,
  output logic      conflict,
  output gain_sel_e gain_sel,
  output logic      dac_pass,
  output logic      rx_live
);

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              conflict_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      conflict <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      conflict <= conflict_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    conflict_d = conflict;
    gain_sel   = GSEL_ZERO;
    dac_pass   = 1'b0;
    rx_live    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_req && rx_req) begin
          conflict_d = 1'b1;
        end else if (tx_req) begin
          state_d = TX_SETUP;
          cnt_d   = settle_load(TX_SETTLE);
        end else if (rx_req) begin
          state_d = RX_SETUP;
          cnt_d   = settle_load(RX_SETTLE);
        end
      end
      TX_SETUP: begin
        if (!tx_req)            state_d = TX_DRAIN;
        else if (cnt_q == '0)   state_d = TX_ACTIVE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      TX_ACTIVE: begin
        if (!tx_req) state_d = TX_DRAIN;
      end
      TX_DRAIN: begin
        state_d = IDLE;
      end
      RX_SETUP: begin
        if (!rx_req)            state_d = IDLE;
        else if (cnt_q == '0)   state_d = RX_ACTIVE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      RX_ACTIVE: begin
        if (!rx_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Datapath selects follow the state being entered on this edge.
    unique case (state_d)
      TX_ACTIVE: begin
        gain_sel = GSEL_TX;
        dac_pass = 1'b1;
      end
      RX_SETUP:  gain_sel = GSEL_RX;
      RX_ACTIVE: begin
        gain_sel = GSEL_RX;
        rx_live  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en    <= 1'b0;
      rx_en    <= 1'b0;
      tx_ready <= 1'b0;
      rx_ready <= 1'b0;
    end else begin
      tx_en    <= state_d inside {TX_SETUP, TX_ACTIVE, TX_DRAIN};
      rx_en    <= state_d inside {RX_SETUP, RX_ACTIVE};
      tx_ready <= (state_d == TX_ACTIVE);
      rx_ready <= (state_d == RX_ACTIVE);
    end
  end

endmodule

// File: rtl/radio_bridge_seq.sv
// Radio bridge top: registered DAC/ADC/RSSI/gain paths gated by the Tx/Rx
// mode sequencer.
module radio_bridge_seq
  import radio_bridge_pkg::*;
#(
  parameter int DAC_WIDTH     = DEF_DAC_WIDTH,
  parameter int ADC_WIDTH     = DEF_ADC_WIDTH,
  parameter int RSSI_WIDTH    = DEF_RSSI_WIDTH,
  parameter int TX_GAIN_WIDTH = DEF_TX_GAIN_WIDTH,
  parameter int RF_GAIN_WIDTH = DEF_RF_GAIN_WIDTH,
  parameter int BB_GAIN_WIDTH = DEF_BB_GAIN_WIDTH,
  parameter int B_WIDTH       = DEF_B_WIDTH,
  parameter int TX_SETTLE     = DEF_TX_SETTLE,
  parameter int RX_SETTLE     = DEF_RX_SETTLE
) (
  input logic               converter_clock_in,
  input logic               converter_reset_n,
  radio_bridge_seq_if.slave bus
);

  logic      tx_en;
  logic      rx_en;
  logic      tx_ready;
  logic      rx_ready;
  logic      conflict;
  gain_sel_e gain_sel;
  logic      dac_pass;
  logic      rx_live;

  logic signed [DAC_WIDTH-1:0]  dac_i_p1;
  logic signed [DAC_WIDTH-1:0]  dac_q_p1;
  logic signed [ADC_WIDTH-1:0]  adc_i_p1;
  logic signed [ADC_WIDTH-1:0]  adc_q_p1;
  logic                         vld_p1;
  logic        [RSSI_WIDTH-1:0] rssi_p1;
  logic        [B_WIDTH-1:0]    gain_p1;

  function automatic logic signed [DAC_WIDTH-1:0] blank_dac(
    input logic                        pass,
    input logic signed [DAC_WIDTH-1:0] sample
  );
    return pass ? sample : '0;
  endfunction

  function automatic logic [B_WIDTH-1:0] gain_word(
    input gain_sel_e                sel,
    input logic [TX_GAIN_WIDTH-1:0] tx_gain,
    input logic [RF_GAIN_WIDTH-1:0] rf_gain,
    input logic [BB_GAIN_WIDTH-1:0] bb_gain
  );
    logic [B_WIDTH-1:0] word;
    word = '0;
    case (sel)
      GSEL_TX: word = B_WIDTH'({1'b0, tx_gain});
      GSEL_RX: word = B_WIDTH'({rf_gain, bb_gain});
      default: word = '0;
    endcase
    return word;
  endfunction

  radio_mode_fsm #(
    .TX_SETTLE (TX_SETTLE),
    .RX_SETTLE (RX_SETTLE)
  ) u_fsm (
    .clk      (converter_clock_in),
    .rst_n    (converter_reset_n),
    .tx_req   (bus.controller_TxEn),
    .rx_req   (bus.controller_RxEn),
    .tx_en    (tx_en),
    .rx_en    (rx_en),
    .tx_ready (tx_ready),
    .rx_ready (rx_ready),
    .conflict (conflict),
    .gain_sel (gain_sel),
    .dac_pass (dac_pass),
    .rx_live  (rx_live)
  );

  // Stage p1: every converter-side path is one register deep.
  always_ff @(posedge converter_clock_in or negedge converter_reset_n) begin
    if (!converter_reset_n) begin
      dac_i_p1 <= '0;
      dac_q_p1 <= '0;
      adc_i_p1 <= '0;
      adc_q_p1 <= '0;
      vld_p1   <= 1'b0;
      rssi_p1  <= '0;
      gain_p1  <= '0;
    end else begin
      dac_i_p1 <= blank_dac(dac_pass, bus.user_DAC_I);
      dac_q_p1 <= blank_dac(dac_pass, bus.user_DAC_Q);
      adc_i_p1 <= bus.radio_ADC_I;
      adc_q_p1 <= bus.radio_ADC_Q;
      vld_p1   <= rx_live;
      rssi_p1  <= bus.radio_RSSI_ADC_D;
      gain_p1  <= gain_word(gain_sel, bus.user_Tx_gain, bus.user_RxRF_gain,
                            bus.user_RxBB_gain);
    end
  end

  assign bus.radio_DAC_I     = dac_i_p1;
  assign bus.radio_DAC_Q     = dac_q_p1;
  assign bus.user_ADC_I      = adc_i_p1;
  assign bus.user_ADC_Q      = adc_q_p1;
  assign bus.user_ADC_valid  = vld_p1;
  assign bus.user_RSSI_ADC_D = rssi_p1;
  assign bus.radio_B         = gain_p1;
  assign bus.radio_TxEn      = tx_en;
  assign bus.radio_RxEn      = rx_en;
  assign bus.tx_ready        = tx_ready;
  assign bus.rx_ready        = rx_ready;
  assign bus.mode_conflict   = conflict;

endmodule

// File: tb/tb_radio_bridge_seq.sv
// Bench for radio_bridge_seq: vector table, directed corner sequences and a
// randomized run against a cycle-age reference model.
module tb_radio_bridge_seq;

  localparam int TXS = 8;
  localparam int RXS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  radio_bridge_seq_if bus ();

  radio_bridge_seq dut (
    .converter_clock_in (clk),
    .converter_reset_n  (rst_n),
    .bus                (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=idle 1=tx 2=rx, age = edges since the mode was entered.
  int  m_mode;
  int  m_age;
  bit  m_drain;
  bit  m_conf;
  bit  seen_txr;

  bit                 e_txen, e_rxen, e_txr, e_rxr, e_vld;
  logic        [6:0]  e_b;
  logic signed [15:0] e_dac_i, e_dac_q;
  logic signed [13:0] e_adc_i, e_adc_q;
  logic        [9:0]  e_rssi;

  typedef struct {
    string      nm;
    bit         tx;
    bit         rx;
    logic [5:0] tg;
    logic [1:0] rf;
    logic [4:0] bb;
    logic [15:0] dac;
    int         n;
    bit         x_txen;
    bit         x_rxen;
    logic [6:0] x_b;
    logic [15:0] x_dac;
    bit         x_txr;
    bit         x_rxr;
    bit         x_vld;
    bit         x_conf;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(string nm, bit tx, bit rx, logic [5:0] tg, logic [1:0] rf,
                              logic [4:0] bb, logic [15:0] dac, int n, bit xte, bit xre,
                              logic [6:0] xb, logic [15:0] xd, bit xtr, bit xrr, bit xv,
                              bit xc);
    vec_t v;
    v.nm = nm; v.tx = tx; v.rx = rx; v.tg = tg; v.rf = rf; v.bb = bb; v.dac = dac; v.n = n;
    v.x_txen = xte; v.x_rxen = xre; v.x_b = xb; v.x_dac = xd;
    v.x_txr = xtr; v.x_rxr = xrr; v.x_vld = xv; v.x_conf = xc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_drain = 1'b0; m_conf = 1'b0;
    e_txen = 1'b0; e_rxen = 1'b0; e_txr = 1'b0; e_rxr = 1'b0; e_vld = 1'b0;
    e_b = '0; e_dac_i = '0; e_dac_q = '0; e_adc_i = '0; e_adc_q = '0; e_rssi = '0;
  endtask

  task automatic model_edge();
    bit t, r, tx_act, rx_act;
    t = bus.controller_TxEn;
    r = bus.controller_RxEn;
    case (m_mode)
      0: begin
        if (t && r) m_conf = 1'b1;
        else if (t) begin m_mode = 1; m_age = 0; end
        else if (r) begin m_mode = 2; m_age = 0; end
      end
      1: begin
        if (m_drain) begin m_mode = 0; m_drain = 1'b0; end
        else if (!t) m_drain = 1'b1;
        else if (m_age < 255) m_age++;
      end
      default: begin
        if (!r) m_mode = 0;
        else if (m_age < 255) m_age++;
      end
    endcase
    tx_act  = (m_mode == 1) && !m_drain && (m_age >= TXS);
    rx_act  = (m_mode == 2) && (m_age >= RXS);
    e_txen  = (m_mode == 1);
    e_rxen  = (m_mode == 2);
    e_txr   = tx_act;
    e_rxr   = rx_act;
    e_vld   = rx_act;
    e_b     = tx_act ? {1'b0, bus.user_Tx_gain}
            : (m_mode == 2) ? {bus.user_RxRF_gain, bus.user_RxBB_gain} : 7'd0;
    e_dac_i = tx_act ? bus.user_DAC_I : 16'sd0;
    e_dac_q = tx_act ? bus.user_DAC_Q : 16'sd0;
    e_adc_i = bus.radio_ADC_I;
    e_adc_q = bus.radio_ADC_Q;
    e_rssi  = bus.radio_RSSI_ADC_D;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".txen"},  32'(bus.radio_TxEn),      32'(e_txen));
    chk({tag, ".rxen"},  32'(bus.radio_RxEn),      32'(e_rxen));
    chk({tag, ".B"},     32'(bus.radio_B),         32'(e_b));
    chk({tag, ".dac_i"}, 32'(bus.radio_DAC_I),     32'(e_dac_i));
    chk({tag, ".dac_q"}, 32'(bus.radio_DAC_Q),     32'(e_dac_q));
    chk({tag, ".adc_i"}, 32'(bus.user_ADC_I),      32'(e_adc_i));
    chk({tag, ".adc_q"}, 32'(bus.user_ADC_Q),      32'(e_adc_q));
    chk({tag, ".rssi"},  32'(bus.user_RSSI_ADC_D), 32'(e_rssi));
    chk({tag, ".valid"}, 32'(bus.user_ADC_valid),  32'(e_vld));
    chk({tag, ".txrdy"}, 32'(bus.tx_ready),        32'(e_txr));
    chk({tag, ".rxrdy"}, 32'(bus.rx_ready),        32'(e_rxr));
    chk({tag, ".conf"},  32'(bus.mode_conflict),   32'(m_conf));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
  endtask

  task automatic cyc(input string tag);
    step();
    check_all(tag);
    if (bus.tx_ready) seen_txr = 1'b1;
  endtask

  task automatic rand_data();
    bus.user_Tx_gain     = 6'($urandom);
    bus.user_RxRF_gain   = 2'($urandom);
    bus.user_RxBB_gain   = 5'($urandom);
    bus.user_DAC_I       = 16'($urandom);
    bus.user_DAC_Q       = 16'($urandom);
    bus.radio_ADC_I      = 14'($urandom);
    bus.radio_ADC_Q      = 14'($urandom);
    bus.radio_RSSI_ADC_D = 10'($urandom);
  endtask

  // Asynchronous assertion between edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    bus.controller_TxEn = 1'b0;
    bus.controller_RxEn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = mk("tx_entry",      1, 0, 6'h2A, 2'b00, 5'h00, 16'h1234, 1, 1, 0, 7'h00, 16'h0000, 0, 0, 0, 0);
    tbl[1]  = mk("tx_settle",     1, 0, 6'h2A, 2'b00, 5'h00, 16'h1234, 7, 1, 0, 7'h00, 16'h0000, 0, 0, 0, 0);
    tbl[2]  = mk("tx_active",     1, 0, 6'h2A, 2'b00, 5'h00, 16'h1234, 1, 1, 0, 7'h2A, 16'h1234, 1, 0, 0, 0);
    tbl[3]  = mk("tx_hold",       1, 0, 6'h2A, 2'b00, 5'h00, 16'h1234, 2, 1, 0, 7'h2A, 16'h1234, 1, 0, 0, 0);
    tbl[4]  = mk("tx_drain",      0, 0, 6'h2A, 2'b00, 5'h00, 16'h1234, 1, 1, 0, 7'h00, 16'h0000, 0, 0, 0, 0);
    tbl[5]  = mk("tx_idle",       0, 0, 6'h2A, 2'b00, 5'h00, 16'h1234, 1, 0, 0, 7'h00, 16'h0000, 0, 0, 0, 0);
    tbl[6]  = mk("rx_entry",      0, 1, 6'h00, 2'b10, 5'h11, 16'h0000, 1, 0, 1, 7'h51, 16'h0000, 0, 0, 0, 0);
    tbl[7]  = mk("rx_settle",     0, 1, 6'h00, 2'b10, 5'h11, 16'h0000, 15, 0, 1, 7'h51, 16'h0000, 0, 0, 0, 0);
    tbl[8]  = mk("rx_active",     0, 1, 6'h00, 2'b10, 5'h11, 16'h0000, 1, 0, 1, 7'h51, 16'h0000, 0, 1, 1, 0);
    tbl[9]  = mk("rx_drop",       0, 0, 6'h00, 2'b10, 5'h11, 16'h0000, 1, 0, 0, 7'h00, 16'h0000, 0, 0, 0, 0);
    tbl[10] = mk("conflict",      1, 1, 6'h15, 2'b01, 5'h03, 16'h7777, 1, 0, 0, 7'h00, 16'h0000, 0, 0, 0, 1);
    tbl[11] = mk("conflict_hold", 0, 0, 6'h15, 2'b01, 5'h03, 16'h7777, 3, 0, 0, 7'h00, 16'h0000, 0, 0, 0, 1);

    // Reset held with random inputs.
    model_reset();
    bus.controller_TxEn = 1'($urandom);
    bus.controller_RxEn = 1'($urandom);
    rand_data();
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("reset_hold");
      bus.controller_TxEn = 1'($urandom);
      bus.controller_RxEn = 1'($urandom);
      rand_data();
    end
    bus.controller_TxEn  = 1'b0;
    bus.controller_RxEn  = 1'b0;
    bus.user_Tx_gain     = '0;
    bus.user_RxRF_gain   = '0;
    bus.user_RxBB_gain   = '0;
    bus.user_DAC_I       = '0;
    bus.user_DAC_Q       = '0;
    bus.radio_ADC_I      = '0;
    bus.radio_ADC_Q      = '0;
    bus.radio_RSSI_ADC_D = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) cyc("post_reset");

    // Vector table.
    for (int r = 0; r < 12; r++) begin
      bus.controller_TxEn = tbl[r].tx;
      bus.controller_RxEn = tbl[r].rx;
      bus.user_Tx_gain    = tbl[r].tg;
      bus.user_RxRF_gain  = tbl[r].rf;
      bus.user_RxBB_gain  = tbl[r].bb;
      bus.user_DAC_I      = tbl[r].dac;
      bus.user_DAC_Q      = tbl[r].dac;
      for (int k = 0; k < tbl[r].n; k++) begin
        step();
        chk({tbl[r].nm, ".txen"},  32'(bus.radio_TxEn),     32'(tbl[r].x_txen));
        chk({tbl[r].nm, ".rxen"},  32'(bus.radio_RxEn),     32'(tbl[r].x_rxen));
        chk({tbl[r].nm, ".B"},     32'(bus.radio_B),        32'(tbl[r].x_b));
        chk({tbl[r].nm, ".dac_i"}, 32'(bus.radio_DAC_I),    32'(tbl[r].x_dac));
        chk({tbl[r].nm, ".txrdy"}, 32'(bus.tx_ready),       32'(tbl[r].x_txr));
        chk({tbl[r].nm, ".rxrdy"}, 32'(bus.rx_ready),       32'(tbl[r].x_rxr));
        chk({tbl[r].nm, ".valid"}, 32'(bus.user_ADC_valid), 32'(tbl[r].x_vld));
        chk({tbl[r].nm, ".conf"},  32'(bus.mode_conflict),  32'(tbl[r].x_conf));
      end
    end
    do_reset("clear_conflict");

    // Abort during Tx setup: drain then idle, never ready.
    seen_txr = 1'b0;
    rand_data();
    bus.controller_TxEn = 1'b1;
    cyc("abort_entry");
    for (int i = 0; i < 3; i++) cyc("abort_setup");
    bus.controller_TxEn = 1'b0;
    cyc("abort_drain");
    chk("abort_drain_txen", 32'(bus.radio_TxEn), 32'd1);
    cyc("abort_idle");
    chk("abort_idle_txen", 32'(bus.radio_TxEn), 32'd0);
    chk("abort_no_ready", 32'(seen_txr), 32'd0);

    // Rx request while Tx active is held off until Tx ends.
    bus.controller_TxEn = 1'b1;
    for (int i = 0; i < TXS + 1; i++) cyc("pre_tx");
    chk("tx_ready_up", 32'(bus.tx_ready), 32'd1);
    bus.controller_RxEn = 1'b1;
    for (int i = 0; i < 3; i++) cyc("rx_ignored");
    chk("rx_ignored_en", 32'(bus.radio_RxEn), 32'd0);
    chk("rx_ignored_conf", 32'(bus.mode_conflict), 32'd0);
    bus.controller_TxEn = 1'b0;
    cyc("tx_end_drain");
    cyc("tx_end_idle");
    chk("tx_end_rxen", 32'(bus.radio_RxEn), 32'd0);
    cyc("rx_serviced");
    chk("rx_serviced_en", 32'(bus.radio_RxEn), 32'd1);

    // Asynchronous reset in RX_ACTIVE, then in TX_ACTIVE.
    for (int i = 0; i < RXS; i++) cyc("rx_run");
    chk("rx_valid_up", 32'(bus.user_ADC_valid), 32'd1);
    do_reset("async_rx");
    bus.controller_TxEn = 1'b1;
    rand_data();
    for (int i = 0; i < TXS + 1; i++) cyc("tx_run");
    chk("tx_ready_run", 32'(bus.tx_ready), 32'd1);
    do_reset("async_tx");

    // Randomized run against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) bus.controller_TxEn = ~bus.controller_TxEn;
      if ($urandom_range(0, 11) == 0) bus.controller_RxEn = ~bus.controller_RxEn;
      rand_data();
      cyc("rand");
      if (i % 300 == 299) do_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
